// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, default widths
// and the quotient produced for a zero divisor.
package div_seq_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 5;

  // Widest operand supported; narrower builds slice the low bits.
  localparam int MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_seq_step.sv
// One restoring shift-subtract step: shift a dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The partial remainder is always below the divisor, so the shifted value
  // needs one extra bit and a successful difference fits back into WIDTH bits.
  assign shifted  = {rem, dvd_bit};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU unit for the EX stage: stalls the front of the pipe,
// then pulses the HI/LO write for the MEM stage.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cancel,
  output logic             stall_req,
  output logic             hilo_write_en,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] q_fin;
  logic             accept;
  logic             last_step;

  assign mag_a = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_bit  (dvd[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  // The dividend register shifts left and collects quotient bits from the LSB.
  assign q_fin     = {dvd[WIDTH-2:0], q_bit};
  assign accept    = (state == S_IDLE) && start && !cancel;
  assign last_step = (state == S_RUN) && (cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = (op_b != '0) ? S_RUN : S_ZERO;
      S_RUN:  if (cnt == LAST_CNT) state_nxt = S_DONE;
      S_ZERO: state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (cancel) state_nxt = S_IDLE;
  end

  assign stall_req     = !cancel && (accept || state == S_RUN || state == S_ZERO);
  assign hilo_write_en = (state == S_DONE) && !cancel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      lo_out <= '0;
      hi_out <= '0;
    end else if (!cancel) begin
      if (accept) begin
        if (op_b != '0) begin
          dvd   <= mag_a;
          dvs   <= mag_b;
          neg_q <= signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          neg_r <= signed_op && op_a[WIDTH-1];
          cnt   <= '0;
          rem   <= '0;
        end else begin
          dvd <= op_a;
        end
      end
      if (state == S_RUN) begin
        dvd <= q_fin;
        rem <= rem_nxt;
        cnt <= cnt + 1'b1;
      end
      // Sign fixup lands in the result registers on the edge into DONE.
      if (last_step) begin
        lo_out <= neg_q ? -q_fin : q_fin;
        hi_out <= neg_r ? -rem_nxt : rem_nxt;
      end
      if (state == S_ZERO) begin
        lo_out <= DIV0_QUOT[WIDTH-1:0];
        hi_out <= dvd;
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases, cancel and reset
// mid-operation, then random operands against an arithmetic reference.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        cancel;
  logic        stall_req;
  logic        hilo_write_en;
  logic [31:0] lo_out;
  logic [31:0] hi_out;

  int checks = 0;
  int passed = 0;

  div_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .signed_op     (signed_op),
    .op_a          (op_a),
    .op_b          (op_b),
    .cancel        (cancel),
    .stall_req     (stall_req),
    .hilo_write_en (hilo_write_en),
    .lo_out        (lo_out),
    .hi_out        (hi_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference result {hi, lo} from plain integer division.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a falling edge; issues one divide and checks timing and result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] e;
    int          cyc;
    bit          stall_ok;
    int          exp_lat;
    e       = model(a, b, s);
    exp_lat = (b == 0) ? 2 : 33;
    start = 1'b1; signed_op = s; op_a = a; op_b = b;
    #1 check("stall_c0", stall_req, 1);
    @(posedge clk);
    @(negedge clk);
    op_a = $urandom; op_b = $urandom; signed_op = 1'($urandom);
    cyc = 1; stall_ok = 1'b1;
    while (!hilo_write_en && cyc < 100) begin
      if (!stall_req) stall_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("stall_busy", 64'(stall_ok), 1);
    check("latency", 64'(cyc), 64'(exp_lat));
    check("wr_pulse", hilo_write_en, 1);
    check("lo", lo_out, e[31:0]);
    check("hi", hi_out, e[63:32]);
    check("stall_done", stall_req, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("wr_once", hilo_write_en, 0);
    check("lo_hold", lo_out, e[31:0]);
    check("hi_hold", hi_out, e[63:32]);
    @(negedge clk);
  endtask

  initial begin
    bit wr_seen;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
    #2;
    check("rst_lo", lo_out, 0);
    check("rst_hi", hi_out, 0);
    check("rst_wr", hilo_write_en, 0);
    check("rst_stall_lo", stall_req, 0);
    start = 1'b1; op_b = 32'd1;
    #1 check("rst_stall_follow", stall_req, 1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'h2, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'hFFFF_FFFF, 32'h1, 1'b0);
    run_op(32'd5, 32'd0, 1'b1);

    // Flush at cycle 10 of an operation, restart at cycle 12.
    start = 1'b1; signed_op = 1'b0; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    #1 check("cancel_stall", stall_req, 0);
    @(negedge clk);
    cancel = 1'b0;
    #1;
    check("cancel_idle", stall_req, 0);
    check("cancel_no_wr", hilo_write_en, 0);
    check("cancel_lo_hold", lo_out, 32'hFFFF_FFFF);
    @(negedge clk);
    run_op(32'd1000, 32'd3, 1'b0);

    // Asynchronous reset in the middle of cycle 20.
    start = 1'b1; signed_op = 1'b1; op_a = 32'h1234_5678; op_b = 32'h77;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_lo", lo_out, 0);
    check("arst_hi", hi_out, 0);
    check("arst_stall", stall_req, 0);
    @(negedge clk);
    rst = 1'b0;
    wr_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (hilo_write_en) wr_seen = 1'b1;
    end
    check("arst_no_wr", 64'(wr_seen), 0);
    check("arst_lo_hold", lo_out, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(ra, rb, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
